// File: rtl/chan_bitop_pkg.sv
// Shared types for the lane-wise bit-op pipeline: the per-lane op encoding.
package chan_bitop_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_REV    = 2'b10,
    MODE_INVREV = 2'b11
  } mode_e;
endpackage

// File: rtl/bitop_lane.sv
// One lane of the bit-op engine: pass, invert, bit-reverse, or invert+reverse (pure comb).
import chan_bitop_pkg::*;

module bitop_lane #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] x,
  input  mode_e         mode,
  output logic [DW-1:0] y
);
  logic [DW-1:0] rev;

  always_comb begin
    rev = '0;
    for (int i = 0; i < DW; i++) rev[i] = x[DW-1-i];
  end

  always_comb begin
    case (mode)
      MODE_PASS: y = x;
      MODE_INV:  y = ~x;
      MODE_REV:  y = rev;
      default:   y = ~rev;
    endcase
  end
endmodule

// File: rtl/chan_bitop_pipe.sv
// NCH-lane bit-op engine feeding a registered valid/ready stage with a one-entry skid.
// Define CHAN_BITOP_PARITY_EN to add out_par (per-lane parity of the result, carried with its beat).
import chan_bitop_pkg::*;

module chan_bitop_pipe #(
  parameter int DW  = 8,
  parameter int NCH = 2,
  parameter int CW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic [NCH*MODE_W-1:0] in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NCH*DW-1:0]   out_data,
  output logic [CW-1:0]       xfer_cnt
`ifdef CHAN_BITOP_PARITY_EN
  , output logic [NCH-1:0]    out_par
`endif
);
  logic [NCH*DW-1:0] xf_data;
  logic [NCH*DW-1:0] skid_data_q, out_data_q, out_data_d;
  logic              skid_vld_q, skid_vld_d, out_vld_q, out_vld_d;
  logic [CW-1:0]     xfer_q;
  logic              accept, out_load, out_ld, skid_ld;

  // Ops are applied before storage, so both registers hold finished results.
  for (genvar k = 0; k < NCH; k++) begin : g_lane
    bitop_lane #(.DW(DW)) u_lane (
      .x    (in_data[k*DW +: DW]),
      .mode (mode_e'(in_mode[k*MODE_W +: MODE_W])),
      .y    (xf_data[k*DW +: DW])
    );
  end

  assign in_ready = !skid_vld_q && !rst;

  always_comb begin
    accept     = in_valid && in_ready;
    out_load   = !out_vld_q || out_ready;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (out_load) begin
      out_vld_d  = skid_vld_q || accept;
      skid_vld_d = 1'b0;
    end else if (accept) begin
      skid_vld_d = 1'b1;
    end
    out_ld     = out_load && (skid_vld_q || accept);
    skid_ld    = !out_load && accept;
    out_data_d = skid_vld_q ? skid_data_q : xf_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
      xfer_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      if (out_ld)  out_data_q  <= out_data_d;
      if (skid_ld) skid_data_q <= xf_data;
      if (out_vld_q && out_ready) xfer_q <= xfer_q + CW'(1);
    end
  end

`ifdef CHAN_BITOP_PARITY_EN
  logic [NCH-1:0] xf_par, skid_par_q, out_par_q;

  always_comb begin
    xf_par = '0;
    for (int k = 0; k < NCH; k++) xf_par[k] = ^xf_data[k*DW +: DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_par_q <= '0;
      out_par_q  <= '0;
    end else begin
      if (out_ld)  out_par_q  <= skid_vld_q ? skid_par_q : xf_par;
      if (skid_ld) skid_par_q <= xf_par;
    end
  end

  assign out_par = out_par_q;
`endif

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign xfer_cnt  = xfer_q;
endmodule
